// File: rtl/phrase_player.sv
// Playback sequencer: advances the phrase row at a BPM-derived rate (4 rows per beat),
// latches the four channel words per row and drives per-channel trig/gate and decoded fields.
module phrase_player #(
    parameter int unsigned CLK_HZ   = 100000000,
    parameter int unsigned NOTE_MAX = 107
) (
    input  logic        clk,
    input  logic        rst_active_high,
    input  logic        play_pause,
    input  logic [7:0]  bpm,
    input  logic [15:0] channel_0,
    input  logic [15:0] channel_1,
    input  logic [15:0] channel_2,
    input  logic [15:0] channel_3,
    output logic [3:0]  row,
    output logic        row_tick,
    output logic [3:0]  trig,
    output logic [3:0]  gate,
    output logic [31:0] note_out,
    output logic [23:0] vol_out,
    output logic [7:0]  inst_out
);

    // 4 rows per beat: a row every CLK_HZ*60/(4*bpm) cycles, carried as acc += bpm vs CLK_HZ*15.
    localparam logic [31:0] THRESH   = 32'(CLK_HZ * 15);
    localparam logic [7:0]  NOTE_LIM = 8'(NOTE_MAX);

    typedef enum logic [1:0] {
        IDLE,
        START,
        FETCH,
        RUN
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  row_q, row_d;
    logic [31:0] acc_q, acc_d;
    logic        play_prev_q;
    logic        row_tick_q, row_tick_d;
    logic [3:0]  trig_q, trig_d;
    logic [3:0]  gate_q, gate_d;
    logic [31:0] note_q, note_d;
    logic [23:0] vol_q, vol_d;
    logic [7:0]  inst_q, inst_d;

    logic [15:0] word [4];
    logic [31:0] sum;

    assign word[0] = channel_0;
    assign word[1] = channel_1;
    assign word[2] = channel_2;
    assign word[3] = channel_3;
    assign sum     = acc_q + {24'd0, bpm};

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        acc_d      = acc_q;
        row_tick_d = 1'b0;
        trig_d     = '0;
        gate_d     = gate_q;
        note_d     = note_q;
        vol_d      = vol_q;
        inst_d     = inst_q;

        // Pause wins over everything: row, acc and fields freeze, only the gates drop.
        if (!play_pause) begin
            state_d = IDLE;
            gate_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    gate_d = '0;
                    if (!play_prev_q) begin
                        state_d = START;
                    end
                end
                START: begin
                    row_d   = '0;
                    acc_d   = '0;
                    state_d = FETCH;
                end
                FETCH: begin
                    row_tick_d = 1'b1;
                    for (int unsigned ch = 0; ch < 4; ch++) begin
                        if (word[ch] != 16'hFFFF && word[ch][15:8] <= NOTE_LIM) begin
                            note_d[8*ch +: 8] = word[ch][15:8];
                            vol_d[6*ch +: 6]  = word[ch][7:2];
                            inst_d[2*ch +: 2] = word[ch][1:0];
                            trig_d[ch]        = 1'b1;
                            gate_d[ch]        = 1'b1;
                        end
                    end
                    state_d = RUN;
                end
                RUN: begin
                    if (sum >= THRESH) begin
                        acc_d   = sum - THRESH;
                        row_d   = row_q + 4'd1;
                        state_d = FETCH;
                    end else begin
                        acc_d = sum;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_active_high) begin
        if (rst_active_high) begin
            state_q     <= IDLE;
            row_q       <= '0;
            acc_q       <= '0;
            play_prev_q <= 1'b0;
            row_tick_q  <= 1'b0;
            trig_q      <= '0;
            gate_q      <= '0;
            note_q      <= '0;
            vol_q       <= '0;
            inst_q      <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            acc_q       <= acc_d;
            play_prev_q <= play_pause;
            row_tick_q  <= row_tick_d;
            trig_q      <= trig_d;
            gate_q      <= gate_d;
            note_q      <= note_d;
            vol_q       <= vol_d;
            inst_q      <= inst_d;
        end
    end

    assign row      = row_q;
    assign row_tick = row_tick_q;
    assign trig     = trig_q;
    assign gate     = gate_q;
    assign note_out = note_q;
    assign vol_out  = vol_q;
    assign inst_out = inst_q;

endmodule
